// File: rtl/jedro_1_dmem_arbiter.sv
// jedro_1_dmem_arbiter: two-master arbiter for the single-port jedro-1 data RAM.
// Define JEDRO_1_DMEM_ARB_RR_EN for round-robin on conflict (default: port 0 wins).
module jedro_1_dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int N_BE       = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  p0_req_i,
  input  logic                  p0_lock_i,
  input  logic [DATA_WIDTH-1:0] p0_addr_i,
  input  logic [N_BE-1:0]       p0_we_i,
  input  logic [DATA_WIDTH-1:0] p0_wdata_i,
  output logic                  p0_gnt_o,
  output logic                  p0_rvalid_o,
  output logic [DATA_WIDTH-1:0] p0_rdata_o,
  input  logic                  p1_req_i,
  input  logic                  p1_lock_i,
  input  logic [DATA_WIDTH-1:0] p1_addr_i,
  input  logic [N_BE-1:0]       p1_we_i,
  input  logic [DATA_WIDTH-1:0] p1_wdata_i,
  output logic                  p1_gnt_o,
  output logic                  p1_rvalid_o,
  output logic [DATA_WIDTH-1:0] p1_rdata_o,
  output logic                  ram_en_o,
  output logic [DATA_WIDTH-1:0] ram_addr_o,
  output logic [N_BE-1:0]       ram_we_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

  owner_e owner_q, owner_d;
  logic   last_q, last_d;
  logic   rsp_vld_q, rsp_vld_d;
  logic   rsp_id_q, rsp_id_d;
  logic   rsp_rd_q, rsp_rd_d;
  logic   gnt0, gnt1;
  logic   conflict_p1;

`ifdef JEDRO_1_DMEM_ARB_RR_EN
  // Round-robin: on conflict the port that did not win last time goes.
  assign conflict_p1 = ~last_q;
`else
  // Fixed priority: the LSU always wins a conflict.
  assign conflict_p1 = 1'b0;
`endif

  // Grant decision; nothing is granted while in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rstn_i) begin
      unique case (owner_q)
        OWN_P0: gnt0 = p0_req_i;
        OWN_P1: gnt1 = p1_req_i;
        default: begin
          if (p0_req_i && p1_req_i) begin
            gnt1 = conflict_p1;
            gnt0 = ~conflict_p1;
          end else begin
            gnt0 = p0_req_i;
            gnt1 = p1_req_i;
          end
        end
      endcase
    end
  end

  // RAM request mux; idle bus is all zero so no spurious writes.
  always_comb begin
    ram_en_o    = gnt0 | gnt1;
    ram_addr_o  = '0;
    ram_we_o    = '0;
    ram_wdata_o = '0;
    unique case (1'b1)
      gnt0: begin
        ram_addr_o  = p0_addr_i;
        ram_we_o    = p0_we_i;
        ram_wdata_o = p0_wdata_i;
      end
      gnt1: begin
        ram_addr_o  = p1_addr_i;
        ram_we_o    = p1_we_i;
        ram_wdata_o = p1_wdata_i;
      end
      default: ;
    endcase
  end

  // Next ownership, last winner and pending response.
  always_comb begin
    owner_d   = owner_q;
    last_d    = last_q;
    rsp_vld_d = gnt0 | gnt1;
    rsp_id_d  = gnt1;
    rsp_rd_d  = 1'b0;
    if (gnt0) begin
      last_d   = 1'b0;
      owner_d  = p0_lock_i ? OWN_P0 : OWN_NONE;
      rsp_rd_d = (p0_we_i == '0);
    end else if (gnt1) begin
      last_d   = 1'b1;
      owner_d  = p1_lock_i ? OWN_P1 : OWN_NONE;
      rsp_rd_d = (p1_we_i == '0);
    end
  end

  // Arbiter state; reset drops locks and any pending response.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      owner_q   <= OWN_NONE;
      last_q    <= 1'b1;
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= 1'b0;
      rsp_rd_q  <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      last_q    <= last_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_id_q  <= rsp_id_d;
      rsp_rd_q  <= rsp_rd_d;
    end
  end

  assign p0_gnt_o    = gnt0;
  assign p1_gnt_o    = gnt1;
  assign p0_rvalid_o = rsp_vld_q & ~rsp_id_q;
  assign p1_rvalid_o = rsp_vld_q & rsp_id_q;
  assign p0_rdata_o  = (p0_rvalid_o && rsp_rd_q) ? ram_rdata_i : '0;
  assign p1_rdata_o  = (p1_rvalid_o && rsp_rd_q) ? ram_rdata_i : '0;

endmodule

// File: tb/tb_jedro_1_dmem_arbiter.sv
// tb_jedro_1_dmem_arbiter: vector table, corner sequences and random traffic
// checked against a transaction-level arbiter model.
module tb_jedro_1_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        p0_req, p0_lock, p1_req, p1_lock;
  logic [3:0]  p0_we, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata, ram_rdata;
  logic        p0_gnt, p1_gnt, p0_rv, p1_rv, ram_en;
  logic [31:0] p0_rd, p1_rd, ram_addr, ram_wdata;
  logic [3:0]  ram_we;
  logic [136:0] obs;

  int n_vec = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  jedro_1_dmem_arbiter dut (
    .clk_i(clk), .rstn_i(rstn),
    .p0_req_i(p0_req), .p0_lock_i(p0_lock), .p0_addr_i(p0_addr),
    .p0_we_i(p0_we), .p0_wdata_i(p0_wdata), .p0_gnt_o(p0_gnt),
    .p0_rvalid_o(p0_rv), .p0_rdata_o(p0_rd),
    .p1_req_i(p1_req), .p1_lock_i(p1_lock), .p1_addr_i(p1_addr),
    .p1_we_i(p1_we), .p1_wdata_i(p1_wdata), .p1_gnt_o(p1_gnt),
    .p1_rvalid_o(p1_rv), .p1_rdata_o(p1_rd),
    .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_we_o(ram_we),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  assign obs = {p0_gnt, p1_gnt, ram_en, ram_we, ram_addr, ram_wdata,
                p0_rv, p1_rv, p0_rd, p1_rd};

  typedef struct {
    logic r0, l0; logic [3:0] we0; logic [31:0] a0, d0;
    logic r1, l1; logic [3:0] we1; logic [31:0] a1, d1;
    logic [31:0] rd;
    logic [136:0] exp;
  } vec_t;

  function automatic logic [136:0] pk(
    logic g0, logic g1, logic en, logic [3:0] we, logic [31:0] a,
    logic [31:0] wd, logic v0, logic v1, logic [31:0] r0, logic [31:0] r1);
    return {g0, g1, en, we, a, wd, v0, v1, r0, r1};
  endfunction

  function automatic vec_t mkv(
    logic r0, logic l0, logic [3:0] we0, logic [31:0] a0, logic [31:0] d0,
    logic r1, logic l1, logic [3:0] we1, logic [31:0] a1, logic [31:0] d1,
    logic [31:0] rd, logic [136:0] exp);
    vec_t v;
    v.r0 = r0; v.l0 = l0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.l1 = l1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
    v.rd = rd; v.exp = exp;
    return v;
  endfunction

  // Transaction-level model: who owns the bus, who won last, what is owed.
  int   m_owner;
  int   m_last;
  bit   m_pv;
  int   m_pid;
  bit   m_pr;

  task automatic model_reset();
    m_owner = -1; m_last = 1; m_pv = 0; m_pid = 0; m_pr = 0;
  endtask

  function automatic int m_win();
    if (!rstn) return -1;
    if (m_owner == 0) return p0_req ? 0 : -1;
    if (m_owner == 1) return p1_req ? 1 : -1;
    if (p0_req && p1_req) begin
`ifdef JEDRO_1_DMEM_ARB_RR_EN
      return 1 - m_last;
`else
      return 0;
`endif
    end
    if (p0_req) return 0;
    if (p1_req) return 1;
    return -1;
  endfunction

  function automatic logic [136:0] model_out();
    int w;
    logic v0, v1;
    logic [3:0] we;
    logic [31:0] a, wd, r0, r1;
    w  = m_win();
    v0 = rstn && m_pv && (m_pid == 0);
    v1 = rstn && m_pv && (m_pid == 1);
    r0 = (v0 && m_pr) ? ram_rdata : 32'h0;
    r1 = (v1 && m_pr) ? ram_rdata : 32'h0;
    we = (w == 0) ? p0_we : (w == 1) ? p1_we : 4'h0;
    a  = (w == 0) ? p0_addr : (w == 1) ? p1_addr : 32'h0;
    wd = (w == 0) ? p0_wdata : (w == 1) ? p1_wdata : 32'h0;
    return pk(w == 0, w == 1, w >= 0, we, a, wd, v0, v1, r0, r1);
  endfunction

  task automatic model_update();
    int w;
    w = m_win();
    m_pv = (w >= 0);
    if (w >= 0) begin
      m_last  = w;
      m_pid   = w;
      m_pr    = (w == 0) ? (p0_we == 4'h0) : (p1_we == 4'h0);
      m_owner = ((w == 0) ? p0_lock : p1_lock) ? w : -1;
    end
  endtask

  task automatic chk(string name, logic [136:0] got, logic [136:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(vec_t v);
    p0_req = v.r0; p0_lock = v.l0; p0_we = v.we0;
    p0_addr = v.a0; p0_wdata = v.d0;
    p1_req = v.r1; p1_lock = v.l1; p1_we = v.we1;
    p1_addr = v.a1; p1_wdata = v.d1;
    ram_rdata = v.rd;
  endtask

  task automatic apply(vec_t v, bit use_tab, string name);
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
    chk({name, "_model"}, obs, model_out());
    if (use_tab) chk({name, "_table"}, obs, v.exp);
    model_update();
  endtask

  vec_t tab[$];
  vec_t idle;
  vec_t v;

  initial begin
    idle = mkv(0,0,0,0,0, 0,0,0,0,0, 0, '0);

    // Directed table: basic read/write, lock with a gap, lock-without-req.
    tab.push_back(idle);
    tab.push_back(mkv(1,0,4'h0,32'h10,32'hAAAA0000, 0,0,0,0,0, 0,
      pk(1,0,1,4'h0,32'h10,32'hAAAA0000,0,0,0,0)));
    tab.push_back(mkv(0,0,0,0,0, 0,0,0,0,0, 32'hDEADBEEF,
      pk(0,0,0,0,0,0,1,0,32'hDEADBEEF,0)));
    tab.push_back(mkv(0,0,0,0,0, 1,0,4'h3,32'h20,32'h1234ABCD, 32'h11111111,
      pk(0,1,1,4'h3,32'h20,32'h1234ABCD,0,0,0,0)));
    tab.push_back(mkv(0,0,0,0,0, 0,0,0,0,0, 32'h99999999,
      pk(0,0,0,0,0,0,0,1,0,0)));
    tab.push_back(mkv(0,0,0,0,0, 1,1,0,32'h30,0, 0,
      pk(0,1,1,0,32'h30,0,0,0,0,0)));
    tab.push_back(mkv(1,0,0,32'h40,0, 1,1,0,32'h34,0, 32'h0A0A0A0A,
      pk(0,1,1,0,32'h34,0,0,1,0,32'h0A0A0A0A)));
    tab.push_back(mkv(1,0,0,32'h40,0, 0,1,0,32'h34,0, 32'h0B0B0B0B,
      pk(0,0,0,0,0,0,0,1,0,32'h0B0B0B0B)));
    tab.push_back(mkv(1,0,0,32'h40,0, 1,0,0,32'h38,0, 32'h0C0C0C0C,
      pk(0,1,1,0,32'h38,0,0,0,0,0)));
    tab.push_back(mkv(1,0,0,32'h40,0, 0,0,0,0,0, 32'h0D0D0D0D,
      pk(1,0,1,0,32'h40,0,0,1,0,32'h0D0D0D0D)));
    tab.push_back(mkv(0,0,0,0,0, 0,0,0,0,0, 32'h0E0E0E0E,
      pk(0,0,0,0,0,0,1,0,32'h0E0E0E0E,0)));
    tab.push_back(mkv(0,1,0,0,0, 0,0,0,0,0, 0, '0));
    tab.push_back(mkv(0,0,0,0,0, 1,0,0,32'h44,0, 0,
      pk(0,1,1,0,32'h44,0,0,0,0,0)));
    tab.push_back(mkv(0,0,0,0,0, 0,0,0,0,0, 32'h0F0F0F0F,
      pk(0,0,0,0,0,0,0,1,0,32'h0F0F0F0F)));

    // Reset with requests pending: everything must be quiet.
    rstn = 1'b0;
    model_reset();
    drive(mkv(1,1,4'hF,32'h4,32'h5, 1,1,4'hF,32'h8,32'h9, 32'hFFFFFFFF, '0));
    #12;
    chk("reset_quiet", obs, '0);
    drive(idle);
    @(negedge clk);
    rstn = 1'b1;

    foreach (tab[i]) apply(tab[i], 1, $sformatf("tab%0d", i));

    // Continuous conflict right after reset.
    @(posedge clk); #1;
    rstn = 1'b0;
    model_reset();
    #2 rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      apply(mkv(1,0,0,32'h50,0, 1,0,0,32'h60,0, i, '0), 0, "conflict");
`ifdef JEDRO_1_DMEM_ARB_RR_EN
      chk($sformatf("conflict_gnt%0d", i), {p0_gnt, p1_gnt},
          (i % 2 == 0) ? 2'b10 : 2'b01);
`else
      chk($sformatf("conflict_gnt%0d", i), {p0_gnt, p1_gnt}, 2'b10);
`endif
    end
    apply(idle, 0, "conflict_drain");

    // Async reset one cycle after a locked p0 read grant.
    apply(mkv(1,1,0,32'h70,0, 0,0,0,0,0, 0, '0), 0, "lock_p0");
    chk("lock_p0_gnt", p0_gnt, 1);
    @(posedge clk); #1;
    rstn = 1'b0;
    model_reset();
    #1;
    chk("midlock_rst_quiet", obs, '0);
    drive(mkv(0,1,0,0,0, 1,0,0,32'h74,0, 32'h77777777, '0));
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("p0_rvalid_dropped", p0_rv, 0);
    chk("p1_gnt_after_rst", p1_gnt, 1);
    chk("after_rst_model", obs, model_out());
    model_update();
    apply(mkv(0,1,0,0,0, 0,0,0,0,0, 32'h88888888, '0), 0, "after_rst_rsp");
    chk("after_rst_p1_rdata", p1_rd, 32'h88888888);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      v.r0  = ($urandom_range(0, 9) < 6);
      v.l0  = ($urandom_range(0, 9) < 2);
      v.we0 = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
      v.a0  = $urandom;
      v.d0  = $urandom;
      v.r1  = ($urandom_range(0, 9) < 6);
      v.l1  = ($urandom_range(0, 9) < 2);
      v.we1 = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
      v.a1  = $urandom;
      v.d1  = $urandom;
      v.rd  = $urandom;
      v.exp = '0;
      apply(v, 0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/jedro_1_dmem_arbiter.md
# jedro_1_dmem_arbiter

Two-master arbiter for the single-port data RAM of the jedro-1 core. Port 0 is the load-store unit and port 1 is a secondary master (debug/program loader). The arbiter grants at most one access per cycle, drives the RAM with the granted request, and routes the one-cycle-latency read data back to the owner. It supports atomic multi-cycle locking and either round-robin or fixed-priority conflict resolution.

## Interface
Parameters:
- DATA_WIDTH, 32, width of data and address buses.
- N_BE, 4, number of byte-write-enable bits (DATA_WIDTH/8).

Ports:
- clk_i  in  1  core clock; all state updates on its rising edge.
- rstn_i  in  1  asynchronous, active-low reset.
- p0_req_i / p1_req_i  in  1  access request, held until granted.
- p0_lock_i / p1_lock_i  in  1  keep ownership after this granted access.
- p0_addr_i / p1_addr_i  in  DATA_WIDTH  byte address.
- p0_we_i / p1_we_i  in  N_BE  byte write enables; all-zero means read.
- p0_wdata_i / p1_wdata_i  in  DATA_WIDTH  write data.
- p0_gnt_o / p1_gnt_o  out  1  combinational grant; the access is accepted this cycle.
- p0_rvalid_o / p1_rvalid_o  out  1  response for the access granted in the previous cycle.
- p0_rdata_o / p1_rdata_o  out  DATA_WIDTH  read data; zero unless rvalid is high and the access was a read.
- ram_en_o  out  1  RAM access enable.
- ram_addr_o  out  DATA_WIDTH  RAM address.
- ram_we_o  out  N_BE  RAM byte write enables.
- ram_wdata_o  out  DATA_WIDTH  RAM write data.
- ram_rdata_i  in  DATA_WIDTH  RAM read data, valid one cycle after the access.

## Operation
- State: owner_q (none/0/1), last_q (last granted port, 0/1), rsp_q (valid, port id, is_read).
- Grant: if owner_q names port k, only port k may be granted; if it is not requesting, nothing is granted and the other port stalls. Otherwise:
  - A single requester is granted.
  - On conflict, the port given by the conflict policy (see Configuration) is granted.
- At most one gnt_o is high per cycle. ram_en_o equals OR of gnt_o. ram_addr_o, ram_we_o and ram_wdata_o are muxed from the granted port. With no grant they are 0, so no spurious writes occur.
- On a grant to port k: last_q <= k. owner_q <= k if pk_lock_i is high, else none.
- rsp_q <= {OR of gnt, k, pk_we_i==0}. pk_rvalid_o = rsp_q.valid && rsp_q.id==k. pk_rdata_o = ram_rdata_i when that port's rvalid is high and is_read is set, else 0.
- Writes also receive an rvalid pulse as a write acknowledgement, with rdata 0.

## Timing
- Grant is combinational in the request cycle N. The RAM samples at the end of N. rvalid/rdata appear in N+1.
- Throughput is one access per cycle, back-to-back, with no bubbles. The next grant in N+1 may coexist with the rvalid for N.
- Reset (asynchronous): owner_q=none, last_q=1, rsp_q.valid=0. While rstn_i is low:
  - all gnt_o, rvalid_o and ram_en_o are 0;
  - ram_we_o, ram_addr_o and ram_wdata_o are 0;
  - rdata_o are 0.
- Reset during a lock releases the lock. A response pending at reset is dropped, with no rvalid afterwards.
- Lock release: the first granted access of the owner with lock_i low is the last locked access. The other port may be granted in the following cycle.
- Lock asserted without req has no effect; the lock is only sampled on a grant.

## Configuration
- JEDRO_1_DMEM_ARB_RR_EN defined: on conflict, the port that is not last_q is granted (round-robin). Starvation is bounded to 1 cycle, except under a lock.
- Undefined: fixed priority. On conflict port 0 (LSU) always wins, and last_q is unused for the decision but still updated.

## Test plan
- Reset, then p0 read at addr 0x10 while the RAM returns 0xDEADBEEF next cycle -> p0_gnt_o=1 in cycle N; p0_rvalid_o=1 with p0_rdata_o=0xDEADBEEF in N+1; p1 outputs stay 0.
- p1 write we=4'b0011, addr 0x20, wdata 0x1234ABCD -> ram_we_o=0011 and ram_wdata_o=0x1234ABCD in N; p1_rvalid_o=1 with p1_rdata_o=0 in N+1.
- Both ports request continuously for 4 cycles after reset -> with RR_EN the grants are p0,p1,p0,p1; without it, p0 gets all 4 and p1_gnt_o stays 0.
- p1 locked for 3 accesses (lock high, high, low) while p0 requests throughout -> p1 is granted 3 consecutive cycles, p0 is first granted on the 4th; a 1-cycle gap in p1 req during the lock gives no grant to anyone.
- rstn_i is pulsed low asynchronously mid-lock, one cycle after a p0 read grant -> rvalid never appears. After reset, p1 is granted immediately, even while p0_lock_i is high.
